// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA feed a byte FIFO that
// is drained onto the serial line; STATUS exposes overflow, busy and full.
module uart_tx_mmio #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wen,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned DIVISOR = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned BW      = $clog2(DIVISOR);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = PW + 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bus decode
  logic       sel;
  logic [3:0] off;
  logic       wr_data;
  logic       wr_status;

  assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = mem_addr[3:0];
  assign wr_data   = sel && mem_wen && (off == OFF_TXDATA);
  assign wr_status = sel && mem_wen && (off == OFF_STATUS);

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:8];

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          pop;

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign push  = wr_data && !full;
  assign drop  = wr_data && full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_status) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serialiser FSM
  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          tx_next;
  logic          baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[head];
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is derived from the next state so tx registers in step with it.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_busy = (count != '0) || (state != IDLE);

  always_comb begin
    mem_rdata = '0;
    if (sel && (off == OFF_STATUS)) begin
      mem_rdata = {29'b0, overflow, tx_busy, full};
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the Tile data bus.
- Consumes CPU store traffic to its address window and buffers bytes in a small FIFO.
- Serialises bytes onto a TX pin as 8N1 frames; this is the first off-chip output path beside the LEDs.
- Exposes a status register the CPU polls before writing.

Parameters:
- CLOCK_FREQ, 100_000_000, core clock in Hz.
- BAUD_RATE, 115200, line rate in bits/s. DIVISOR = CLOCK_FREQ/BAUD_RATE, integer-truncated (868 at defaults); must be ≥2.
- FIFO_DEPTH, 8, byte entries; power of two, ≥2.
- BASE_ADDR, 32'h1000_0000, window base; decoded on mem_addr[31:4].

Ports:
- clk  in  1  core clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  CPU data address.
- mem_wdata  in  32  store data; only bits [7:0] used.
- mem_wen  in  1  one-cycle store strobe.
- mem_rdata  out  32  combinational read data for the decoded window; 0 when not selected.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high while FIFO is non-empty or a frame is in flight.

Behaviour:
- Register map, offset = mem_addr[3:0]. Other offsets read 0 and ignore writes.
  - 0x0 TXDATA: a write pushes mem_wdata[7:0]; reads return 0.
  - 0x4 STATUS: read {29'b0, overflow, tx_busy, full}; any write clears overflow.
- Select = (mem_addr[31:4] == BASE_ADDR[31:4]).
- Reset (takes effect at the clock edge where rst=1):
  - FIFO emptied (head/tail/count = 0), overflow = 0.
  - FSM = IDLE; tx = 1, tx_busy = 0, baud and bit counters = 0.
  - Reset mid-frame aborts the frame; tx returns high in the cycle after the edge.
- FIFO:
  - count width = log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH).
  - A push when full is dropped and sets overflow (sticky).
  - The full check uses the pre-edge count: a push arriving in the same cycle as a pop with count==FIFO_DEPTH is still dropped.
  - A simultaneous push and pop with count < FIFO_DEPTH leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop the head into shift reg, baud_cnt=0, go to START.
  - START: tx=0 for DIVISOR cycles, then DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx], LSB first. Each bit lasts DIVISOR cycles. After bit 7, go to STOP.
  - STOP: tx=1 for DIVISOR cycles, then IDLE.
  - Frame = 10*DIVISOR cycles. Back-to-back frames add exactly 1 IDLE cycle between stop and next start.
- Latency: a TXDATA write sampled at edge N into an empty FIFO with FSM idle is popped at edge N+1; tx falls after edge N+1 (start bit visible cycle N+2).
- tx is a registered output, glitch-free.
- tx_busy = (count != 0) || (state != IDLE).

Test Plan:
- Sim params CLOCK_FREQ=100, BAUD_RATE=25 (DIVISOR=4), FIFO_DEPTH=4.
- Reset: hold rst 2 cycles -> tx=1, tx_busy=0, STATUS reads 0.
- Single byte: write 0x55 to TXDATA -> tx low 2 cycles later for 4 cycles, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; tx_busy drops the cycle after stop ends (total 41 cycles from write).
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles -> two frames with exactly 1 idle-high cycle between them; decoded bytes 0xA5, 0x3C.
- Overflow: 6 consecutive writes 0x01..0x06 while idle -> first byte popped at once, 4 queued, 6th dropped. STATUS = 0x7 (overflow, busy, full). Line emits 0x01–0x05 only. Writing STATUS then reads 0x3 until the FIFO drains below full.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF -> tx=1 next cycle, FIFO empty, no further frames after rst deasserts.
- Decode: write 0x41 to BASE_ADDR+0x10 and read BASE_ADDR+0x8 -> no frame starts, mem_rdata=0.
